code_sequencer: RTL

CODE_SEQUENCER -- requirements
Module: code_sequencer

---
 rtl/code_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/code_sequencer.sv
// Switch/button driven 4-bit code sequencer: synchronizes and debounces raw
// inputs, then runs a MANUAL / AUTO / STEP mode FSM that drives a registered code.
module code_sequencer #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned TICK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SW,
    input  logic       BTNC,
    input  logic       BTNU,
    output logic [3:0] code,
    output logic [1:0] mode,
    output logic       tick
);

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        STEP   = 2'b10
    } state_t;

    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    // Input bit map: [3:0] SW, [4] BTNC, [5] BTNU
    logic [5:0]    raw;
    logic [5:0]    sync1;
    logic [5:0]    sync2;
    logic [5:0]    deb;
    logic [DW-1:0] deb_cnt [6];
    logic [1:0]    btn_q;
    logic          pulse_c;
    logic          pulse_u;
    logic [PW-1:0] presc;
    state_t        state;

    assign raw = {BTNU, BTNC, SW};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= '0;
        end else begin
            btn_q <= deb[5:4];
        end
    end

    assign pulse_c = deb[4] & ~btn_q[0];
    assign pulse_u = deb[5] & ~btn_q[1];

    // A mode change takes priority over any step or tick in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MANUAL;
            code  <= '0;
            tick  <= 1'b0;
            presc <= '0;
        end else begin
            tick <= 1'b0;
            if (pulse_c) begin
                presc <= '0;
                case (state)
                    MANUAL:  state <= AUTO;
                    AUTO:    state <= STEP;
                    default: state <= MANUAL;
                endcase
            end else begin
                case (state)
                    MANUAL: begin
                        code  <= deb[3:0];
                        presc <= '0;
                    end
                    AUTO: begin
                        if (presc == TICK_LAST) begin
                            presc <= '0;
                            code  <= code + 4'd1;
                            tick  <= 1'b1;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    STEP: begin
                        presc <= '0;
                        if (pulse_u) begin
                            code <= code + 4'd1;
                        end
                    end
                    default: begin
                        state <= MANUAL;
                        presc <= '0;
                    end
                endcase
            end
        end
    end

    assign mode = state;

endmodule
